// File: rtl/pipe_addsub.sv
// Segmented pipelined WIDTH-bit adder/subtractor: one SEG-bit segment is resolved per stage.
// Define PIPE_ADDSUB_SAT_EN to saturate the result on signed overflow.
module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  logic w_en;

  // The whole pipe shifts together; it may advance whenever the output slot is free or being drained.
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int UW = WIDTH - k * SEG;
    localparam int SW = (k + 1) * SEG;

    logic          w_v;
    logic          w_c;
    logic [UW-1:0] w_a;
    logic [UW-1:0] w_b;
    logic [SEG:0]  w_seg;
    logic [SW-1:0] w_s;
    logic [SW-1:0] w_s_nx;
    logic          r_v;
    logic          r_c;
    logic [SW-1:0] r_s;

    if (k == 0) begin : g_head
      // Subtraction is num1 + ~num2 + !cin.
      assign w_v = in_valid;
      assign w_a = num1;
      assign w_b = sub ? ~num2 : num2;
      assign w_c = cin ^ sub;
      assign w_s = w_seg[SEG-1:0];
    end else begin : g_body
      assign w_v = g_st[k-1].r_v;
      assign w_a = g_st[k-1].g_fwd.r_a;
      assign w_b = g_st[k-1].g_fwd.r_b;
      assign w_c = g_st[k-1].r_c;
      assign w_s = {w_seg[SEG-1:0], g_st[k-1].r_s};
    end

    assign w_seg = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_c};

    if (k < STAGES - 1) begin : g_fwd
      logic [UW-SEG-1:0] r_a;
      logic [UW-SEG-1:0] r_b;

      assign w_s_nx = w_s;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a[UW-1:SEG];
          r_b <= w_b[UW-1:SEG];
        end
      end
    end else begin : g_tail
      logic w_c_msb;
      logic w_ovf;
      logic r_ovf;

      assign w_c_msb = w_a[UW-1] ^ w_b[UW-1] ^ w_seg[SEG-1];
      assign w_ovf   = w_c_msb ^ w_seg[SEG];
`ifdef PIPE_ADDSUB_SAT_EN
      assign w_s_nx = w_ovf ? {w_a[UW-1], {(SW-1){~w_a[UW-1]}}} : w_s;
`else
      assign w_s_nx = w_s;
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_ovf;
        end
      end
    end

    // Empty slots shift through like full ones, so bubbles are never collapsed.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_v;
        r_c <= w_seg[SEG];
        r_s <= w_s_nx;
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign sum       = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;
  assign ovf       = g_st[STAGES-1].g_tail.r_ovf;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub (WIDTH=32, SEG=8): directed vectors, latency,
// backpressure and mid-stream reset; honours PIPE_ADDSUB_SAT_EN for expected sums.
module tb_pipe_addsub;
  localparam int WIDTH  = 32;
  localparam int SEG    = 8;
  localparam int STAGES = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] num1 = '0;
  logic [WIDTH-1:0] num2 = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH+1:0] exp_q[$];
  logic             stall_pending = 1'b0;
  logic [WIDTH+1:0] hold = '0;
  logic             bp_mode = 1'b0;
  int               bp_k = 0;

  pipe_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] sat);
`ifdef PIPE_ADDSUB_SAT_EN
    return sat;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string name, input logic [WIDTH+1:0] got, input logic [WIDTH+1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one beat, hold it until accepted, and log its expected result.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                      input logic s, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    num1 = a; num2 = b; cin = c; sub = s; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back({es, ec, eo});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string name);
    for (int n = 0; n < STAGES; n++) begin
      @(negedge clk); #2;
      chk(name, (WIDTH+2)'(out_valid), (WIDTH+2)'(n == STAGES - 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: handshake-driven scoreboard pop, in_ready rule and stall stability.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        stall_pending = 1'b0;
      end else begin
        chk("in_ready_rule", (WIDTH+2)'(in_ready), (WIDTH+2)'(!(out_valid && !out_ready)));
        if (stall_pending) chk("stall_hold", {sum, cout, ovf}, hold);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got %h expected none", {sum, cout, ovf});
          end else begin
            chk("result", {sum, cout, ovf}, exp_q.pop_front());
          end
        end
        stall_pending = out_valid && !out_ready;
        hold = {sum, cout, ovf};
      end
    end
  end

  // Consumer backpressure pattern 1,0,0 repeating.
  initial begin
    forever begin
      @(negedge clk);
      if (bp_mode) begin
        out_ready = (bp_k % 3 == 0);
        bp_k++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", (WIDTH+2)'(out_valid), '0);
    chk("rst_outputs", {sum, cout, ovf}, '0);
    chk("rst_in_ready", (WIDTH+2)'(in_ready), (WIDTH+2)'(1));
    reset = 1'b0;

    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    lat_check("latency_add");

    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, pick(32'h7FFF_FFFF, 32'h8000_0000), 1'b1, 1'b1);
    send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    send(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pick(32'h8000_0000, 32'h7FFF_FFFF), 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, pick(32'h0000_0000, 32'h8000_0000), 1'b1, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, WIDTH'(2 * i), 1'b0, 1'b0);
    end
    drain();
    @(negedge clk);
    bp_mode = 1'b0;
    out_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      send(WIDTH'((i + 1) * 256), 32'h0000_0011, 1'b0, 1'b0, WIDTH'((i + 1) * 256 + 17), 1'b0, 1'b0);
    end
    repeat (2) @(negedge clk);
    #2;
    chk("pre_reset_valid", (WIDTH+2)'(out_valid), (WIDTH+2)'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_valid", (WIDTH+2)'(out_valid), '0);
    chk("async_rst_outputs", {sum, cout, ovf}, '0);
    chk("async_rst_in_ready", (WIDTH+2)'(in_ready), (WIDTH+2)'(1));
    stall_pending = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;

    send(32'h0000_0040, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_003E, 1'b1, 1'b0);
    lat_check("latency_after_reset");
    drain();
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
